// File: rtl/mtimer.sv
// mtimer: free-running 64-bit mtime with 64-bit mtimecmp, level interrupt, 32-bit register port.
// Define MTIMER_PRESCALE_EN to advance mtime once every PRESCALE clk cycles instead of every cycle.
module mtimer #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        timer_intr
);

    typedef enum logic [1:0] {
        ADDR_MTIME_LO    = 2'd0,
        ADDR_MTIME_HI    = 2'd1,
        ADDR_MTIMECMP_LO = 2'd2,
        ADDR_MTIMECMP_HI = 2'd3
    } reg_addr_e;

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("mtimer: PRESCALE must be in 1..65535");
    end

    logic        tick;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        timer_intr_q, timer_intr_d;

`ifdef MTIMER_PRESCALE_EN
    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;

    // The prescaler free-runs; mtime writes never disturb its phase.
    always_comb begin
        tick    = (presc_q == PRESCALE_LAST);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) presc_q <= '0;
        else       presc_q <= presc_d;
    end
`else
    assign tick = 1'b1;
`endif

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        mtime_d    = mtime_q + {63'd0, tick};
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            // A write to an mtime half wins over the tick; the other half keeps its old value.
            case (wr_addr)
                ADDR_MTIME_LO:    mtime_d         = {mtime_q[63:32], wr_data};
                ADDR_MTIME_HI:    mtime_d         = {wr_data, mtime_q[31:0]};
                ADDR_MTIMECMP_LO: mtimecmp_d[31:0]  = wr_data;
                ADDR_MTIMECMP_HI: mtimecmp_d[63:32] = wr_data;
            endcase
        end
    end

    always_comb begin
        shadow_d     = shadow_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_en;
        timer_intr_d = (mtime_q >= mtimecmp_q);
        if (rd_en) begin
            case (rd_addr)
                ADDR_MTIME_LO: begin
                    rd_data_d = mtime_q[31:0];
                    shadow_d  = mtime_q[63:32];
                end
                ADDR_MTIME_HI:    rd_data_d = shadow_q;
                ADDR_MTIMECMP_LO: rd_data_d = mtimecmp_q[31:0];
                ADDR_MTIMECMP_HI: rd_data_d = mtimecmp_q[63:32];
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            shadow_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            timer_intr_q <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            shadow_q     <= shadow_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            timer_intr_q <= timer_intr_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign timer_intr = timer_intr_q;

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped machine timer that produces the `timer_intr` level consumed by `core`. It holds a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, both accessible over a simple 32-bit register port. It raises `timer_intr` while `mtime >= mtimecmp`, and sits directly upstream of the core's interrupt input.

## Interface
- `PRESCALE`, default 4: number of `clk` cycles per `mtime` tick when prescaling is compiled in; legal range 1..65535.
- `clk  input  1`: system clock; all state updates on the rising edge.
- `rstn  input  1`: asynchronous, active-low reset.
- `wr_en  input  1`: write strobe, one word per cycle.
- `wr_addr  input  2`: word select. 0 = `mtime_lo`, 1 = `mtime_hi`, 2 = `mtimecmp_lo`, 3 = `mtimecmp_hi`.
- `wr_data  input  32`: write data.
- `rd_en  input  1`: read strobe.
- `rd_addr  input  2`: read word select, using the same map as `wr_addr`.
- `rd_data  output  32`: read data; valid when `rd_valid` is high.
- `rd_valid  output  1`: one-cycle pulse, one cycle after `rd_en`.
- `timer_intr  output  1`: registered interrupt level to `core`.

## Operation
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - Prescale counter = 0.
  - Read shadow = 0.
  - `rd_data` = 0, `rd_valid` = 0, `timer_intr` = 0.
- Counting: `mtime` increments by 1 on each tick. It wraps from 2^64-1 to 0 with no flag.
- Compare: `timer_intr` is registered from an unsigned 64-bit `mtime >= mtimecmp` evaluated on current register values. It is a level, not a pulse, and stays high until software raises `mtimecmp` or `mtime` wraps.
- Writes update only the addressed 32-bit half. The other half is unchanged.
- A write to `mtime_lo` or `mtime_hi` in the same cycle as a tick takes priority. The written half takes `wr_data`, the increment is discarded for that cycle, and there is no carry into or out of the written half.
- Read snapshot:
  - Reading `mtime_lo` returns the current low word and copies the current `mtime[63:32]` into a shadow register.
  - Reading `mtime_hi` returns the shadow, not the live value, so lo-then-hi gives a coherent 64-bit value.
  - `mtimecmp` halves read live.
- Same-cycle `rd_en` and `wr_en` to the same address: the read returns the pre-write value.
- Recommended software order for writing `mtimecmp`: hi = FFFF_FFFF, then lo, then hi. No hardware interlock is provided.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Any outstanding read is dropped, so `rd_valid` is forced to 0.

## Timing
- Read latency: `rd_en` in cycle N gives `rd_data` and `rd_valid` in cycle N+1. Back-to-back reads are allowed every cycle.
- Write latency: the register is updated at the end of the `wr_en` cycle. Its effect on `timer_intr` is visible one cycle later.
- Interrupt latency: if `mtime` first equals `mtimecmp` in cycle N, `timer_intr` is high in cycle N+1.
- Deassertion latency: a `mtimecmp` write in cycle N that makes the compare false gives `timer_intr` low in cycle N+2.
- `rd_data` holds its last value while `rd_valid` is 0.

## Configuration
- `MTIMER_PRESCALE_EN` defined:
  - A 16-bit prescale counter counts 0..PRESCALE-1.
  - A tick occurs in the cycle the counter equals PRESCALE-1, and the counter then returns to 0.
  - Writes to `mtime` do not reset the prescale counter.
- `MTIMER_PRESCALE_EN` undefined: a tick occurs every cycle. No prescale counter exists and `PRESCALE` is ignored.

## Test plan
- **Reset:** hold `rstn`=0 for 3 cycles, then release. Required: `timer_intr`=0; reading addr 2 then 3 returns FFFF_FFFF twice; with the macro undefined, `mtime_lo` read at 10 cycles after release returns 9 or 10 (the exact value, fixed by the bench's read point).
- **Compare hit (macro undefined):** write hi=0, then lo=20. Required: `timer_intr` rises exactly one cycle after `mtime` reads 20 and stays high; then writing lo=1000 drops `timer_intr` two cycles later.
- **Prescale (macro defined, PRESCALE=4):** `mtimecmp`=5. Required: `mtime` advances once per 4 cycles; `timer_intr` rises 1 cycle after the 5th tick, 20–21 cycles after reset depending on phase; checked against a reference model.
- **Write/tick collision:** write `mtime_lo`=100 in a tick cycle. Required: next read returns 100 (not 101), and 101 the following tick.
- **Wrap and snapshot:** write `mtime` = FFFF_FFFF_FFFF_FFFE with `mtimecmp`=FFFF_FFFF_FFFF_FFFF. Required: `timer_intr` goes high, then low after the wrap to 0. Separately, set `mtime_lo`=FFFF_FFFF, read lo, wait 3 ticks, read hi. Required: hi returns the pre-carry value.
- **Async reset mid-read:** assert `rstn` low in the `rd_en` cycle. Required: `rd_valid` stays 0 and all registers return to reset values.
